// File: rtl/ps2_pkg.sv
// Shared register map, bit positions and FSM state types for the PS/2 receiver block.
package ps2_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    localparam int ST_OVR  = 7;
    localparam int ST_FERR = 6;
    localparam int ST_PERR = 5;
    localparam int ST_FULL = 4;
    localparam int ST_NE   = 3;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK} bus_state_t;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO succeeds when a pop happens in the same cycle.
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_rx_fifo_68k.sv
// PS/2 keyboard receiver with odd-parity/frame checking, frame timeout, receive FIFO
// and a four-register 68000-style bus slave with interrupt.
module ps2_rx_fifo_68k
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int DTACK_DELAY    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       cs,
    input  logic       ds,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    output logic       dtack_n,
    output logic       irq
);
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DLY_W = $clog2(DTACK_DELAY + 1);

    // Synchronisers idle high, matching an idle PS/2 line.
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev, bit_ev, bit_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign bit_ev  = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_dat = dat_sync[SYNC_STAGES-1];

    rx_state_t        rx_state, rx_next;
    logic [7:0]       rx_shift, shift_n;
    logic [2:0]       rx_cnt, cnt_n;
    logic             rx_par_ok, par_ok_n;
    logic [TMR_W-1:0] rx_tmr, tmr_n;
    logic             rx_good, rx_perr, rx_ferr;
    logic             push_q;
    logic [7:0]       push_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            rx_shift  <= '0;
            rx_cnt    <= '0;
            rx_par_ok <= 1'b0;
            rx_tmr    <= '0;
            push_q    <= 1'b0;
            push_byte <= '0;
        end else begin
            rx_state  <= rx_next;
            rx_shift  <= shift_n;
            rx_cnt    <= cnt_n;
            rx_par_ok <= par_ok_n;
            rx_tmr    <= tmr_n;
            push_q    <= rx_good;
            push_byte <= rx_shift;
        end
    end

    always_comb begin
        rx_next  = rx_state;
        shift_n  = rx_shift;
        cnt_n    = rx_cnt;
        par_ok_n = rx_par_ok;
        tmr_n    = '0;
        rx_good  = 1'b0;
        rx_perr  = 1'b0;
        rx_ferr  = 1'b0;
        if (rx_state != RX_IDLE) tmr_n = bit_ev ? '0 : rx_tmr + TMR_W'(1);
        unique case (rx_state)
            RX_IDLE: if (bit_ev && !bit_dat) begin
                rx_next = RX_DATA;
                cnt_n   = '0;
            end
            RX_DATA: if (bit_ev) begin
                shift_n = {bit_dat, rx_shift[7:1]};
                cnt_n   = rx_cnt + 3'd1;
                if (rx_cnt == 3'd7) rx_next = RX_PARITY;
            end
            RX_PARITY: if (bit_ev) begin
                par_ok_n = ^{rx_shift, bit_dat};
                rx_next  = RX_STOP;
            end
            RX_STOP: if (bit_ev) begin
                rx_next = RX_IDLE;
                if (!rx_par_ok)    rx_perr = 1'b1;
                else if (!bit_dat) rx_ferr = 1'b1;
                else               rx_good = 1'b1;
            end
            default: rx_next = RX_IDLE;
        endcase
        // A stalled frame is abandoned after TIMEOUT_CYCLES quiet cycles.
        if (rx_state != RX_IDLE && !bit_ev && rx_tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            rx_next = RX_IDLE;
            rx_ferr = 1'b1;
            tmr_n   = '0;
        end
    end

    logic          fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [LW-1:0] fifo_level;

    ps2_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .din   (push_byte),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    bus_state_t       b_state, b_next;
    logic [DLY_W-1:0] b_dly, dly_n;
    logic             ack_go, sel;

    assign sel = cs & ds;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state <= B_IDLE;
            b_dly   <= '0;
        end else begin
            b_state <= b_next;
            b_dly   <= dly_n;
        end
    end

    always_comb begin
        b_next = b_state;
        dly_n  = b_dly;
        ack_go = 1'b0;
        unique case (b_state)
            B_IDLE: if (sel) begin
                b_next = B_WAIT;
                dly_n  = '0;
            end
            B_WAIT: begin
                if (!sel) b_next = B_IDLE;
                else if (b_dly == DLY_W'(DTACK_DELAY - 1)) begin
                    b_next = B_ACK;
                    ack_go = 1'b1;
                end else dly_n = b_dly + DLY_W'(1);
            end
            B_ACK: if (!sel) b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
    end

    logic       ovr, ferr, perr, irq_en;
    logic       rd_go, wr_go;
    logic [2:0] clr;
    logic [7:0] rd_data;
    logic       din_unused;

    assign din_unused = ^bus_din[4:2];
    assign rd_go      = ack_go & rw;
    assign wr_go      = ack_go & ~rw;
    assign fifo_pop   = rd_go & (addr == REG_DATA) & ~fifo_empty;
    assign fifo_flush = wr_go & (addr == REG_CTRL) & bus_din[CTRL_FLUSH];
    assign clr        = (wr_go && addr == REG_STATUS) ? bus_din[ST_OVR:ST_PERR] : 3'b0;

    always_comb begin
        rd_data = '0;
        unique case (addr)
            REG_DATA:   rd_data = fifo_empty ? 8'h00 : fifo_dout;
            REG_STATUS: rd_data = {ovr, ferr, perr, fifo_full, ~fifo_empty, 3'b000};
            REG_CTRL:   rd_data = {6'b0, irq_en, 1'b0};
            REG_LEVEL:  rd_data = {{(8-LW){1'b0}}, fifo_level};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr      <= 1'b0;
            ferr     <= 1'b0;
            perr     <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
            bus_dout <= '0;
            dtack_n  <= 1'b1;
            bus_oe   <= 1'b0;
        end else begin
            // Set beats a simultaneous write-one-to-clear.
            ovr  <= (push_q & fifo_full & ~fifo_pop & ~fifo_flush) | (ovr & ~clr[2]);
            ferr <= rx_ferr | (ferr & ~clr[1]);
            perr <= rx_perr | (perr & ~clr[0]);
            if (wr_go && addr == REG_CTRL) irq_en <= bus_din[CTRL_IRQ_EN];
            irq     <= irq_en & (~fifo_empty | ovr | ferr | perr);
            if (rd_go) bus_dout <= rd_data;
            dtack_n <= (b_next != B_ACK);
            bus_oe  <= (b_next == B_ACK) & rw;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo_68k.sv
// Directed bench: PS/2 frames in, register reads/writes over the bus, hand-computed expectations.
module tb_ps2_rx_fifo_68k;
    localparam int DEPTH = 8;
    localparam int TMO   = 5000;
    localparam int DLY   = 1;
    localparam int HALF  = 10;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1;
    logic       cs = 1'b0, ds = 1'b0, rw = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] bus_din = 8'h00;
    logic [7:0] bus_dout;
    logic       bus_oe, dtack_n, irq;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    ps2_rx_fifo_68k #(
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO), .DTACK_DELAY(DLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .cs(cs), .ds(ds), .rw(rw), .addr(addr), .bus_din(bus_din),
        .bus_dout(bus_dout), .bus_oe(bus_oe), .dtack_n(dtack_n), .irq(irq)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~^b ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic bus_cyc(input logic r, input logic [1:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output int lat, output logic oe);
        @(negedge clk);
        cs = 1'b1; ds = 1'b1; rw = r; addr = a; bus_din = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (dtack_n && lat < 20);
        chk("dtack_seen", 8'(dtack_n), 8'd0);
        rd = bus_dout;
        oe = bus_oe;
        cs = 1'b0; ds = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic exp_reg(input string tag, input logic [1:0] a, input logic [7:0] e);
        logic [7:0] d; int lat; logic oe;
        bus_cyc(1'b1, a, 8'h00, d, lat, oe);
        chk(tag, d, e);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] v);
        logic [7:0] d; int lat; logic oe;
        bus_cyc(1'b0, a, v, d, lat, oe);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] d; int lat; logic oe;

        repeat (3) @(negedge clk);
        chk("rst_dtack_n", 8'(dtack_n), 8'd1);
        chk("rst_bus_oe", 8'(bus_oe), 8'd0);
        chk("rst_irq", 8'(irq), 8'd0);
        chk("rst_dout", bus_dout, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_reg("rst_level", 2'd3, 8'h00);
        exp_reg("rst_status", 2'd1, 8'h00);
        exp_reg("rst_ctrl", 2'd2, 8'h00);

        // Good byte, read back with latency and output-enable checks.
        send_frame(8'h1C, 1'b0);
        bus_cyc(1'b1, 2'd0, 8'h00, d, lat, oe);
        chk("data_1c", d, 8'h1C);
        chk("dtack_latency", 8'(lat), 8'(DLY + 1));
        chk("read_oe", 8'(oe), 8'd1);
        exp_reg("level_after_pop", 2'd3, 8'h00);
        bus_cyc(1'b0, 2'd3, 8'hFF, d, lat, oe);
        chk("write_oe", 8'(oe), 8'd0);

        // Bad parity: dropped, PERR set, then cleared.
        send_frame(8'h1C, 1'b1);
        exp_reg("perr_level", 2'd3, 8'h00);
        exp_reg("perr_status", 2'd1, 8'h20);
        wr_reg(2'd1, 8'h20);
        exp_reg("perr_cleared", 2'd1, 8'h00);

        // Overflow: DEPTH+1 bytes, last one lost.
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0);
        exp_reg("ovf_level", 2'd3, 8'(DEPTH));
        exp_reg("ovf_status", 2'd1, 8'h98);
        for (int i = 1; i <= DEPTH; i++) exp_reg($sformatf("ovf_data%0d", i), 2'd0, 8'(i));
        exp_reg("ovf_drained", 2'd3, 8'h00);
        exp_reg("empty_read", 2'd0, 8'h00);
        exp_reg("ovr_sticky", 2'd1, 8'h80);
        wr_reg(2'd1, 8'h80);

        // Timeout after four data bits, then a clean frame.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TMO + 1) @(negedge clk);
        exp_reg("tmo_status", 2'd1, 8'h40);
        send_frame(8'h5A, 1'b0);
        exp_reg("tmo_level", 2'd3, 8'h01);
        exp_reg("tmo_data", 2'd0, 8'h5A);
        wr_reg(2'd1, 8'h40);
        exp_reg("tmo_cleared", 2'd1, 8'h00);

        // Interrupt.
        wr_reg(2'd2, 8'h02);
        exp_reg("ctrl_irq_en", 2'd2, 8'h02);
        chk("irq_idle", 8'(irq), 8'd0);
        send_frame(8'hF0, 1'b0);
        chk("irq_high", 8'(irq), 8'd1);
        exp_reg("irq_data", 2'd0, 8'hF0);
        chk("irq_low", 8'(irq), 8'd0);

        // Flush with three queued.
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        exp_reg("flush_pre_level", 2'd3, 8'h03);
        wr_reg(2'd2, 8'h03);
        exp_reg("flush_level", 2'd3, 8'h00);
        exp_reg("flush_ctrl", 2'd2, 8'h02);
        exp_reg("flush_status", 2'd1, 8'h00);
        exp_reg("flush_empty_read", 2'd0, 8'h00);

        // Reset mid-frame and mid-acknowledge.
        send_frame(8'h77, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        cs = 1'b1; ds = 1'b1; rw = 1'b1; addr = 2'd3;
        for (int i = 0; i < 20 && dtack_n; i++) @(negedge clk);
        chk("pre_rst_dtack", 8'(dtack_n), 8'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_dtack_n", 8'(dtack_n), 8'd1);
        chk("arst_bus_oe", 8'(bus_oe), 8'd0);
        chk("arst_dout", bus_dout, 8'h00);
        chk("arst_irq", 8'(irq), 8'd0);
        cs = 1'b0; ds = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_reg("arst_level", 2'd3, 8'h00);
        exp_reg("arst_ctrl", 2'd2, 8'h00);
        send_frame(8'h3C, 1'b0);
        exp_reg("post_rst_data", 2'd0, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
